// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write/read port bundle for the multi-port GPR file.
//   master : pipeline side, drives write ports, read enables and addresses, samples read data
//   slave  : register file side
//   we0/wa0/wd0, we1/wa1/wd1 : two write ports, W1 wins on an address collision
//   rd_en/rd_addr/rd_data    : NUM_RD packed read ports, port k at [k*W +: W]
//   alloc_en/alloc_addr/rd_pend : pending-producer scoreboard, only with SCOREBOARD_EN defined
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     we0;
    logic [ADDR_W-1:0]        wa0;
    logic [DATA_W-1:0]        wd0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd1;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
`ifdef SCOREBOARD_EN
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic [NUM_RD-1:0]        rd_pend;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, rd_en, rd_addr, alloc_en, alloc_addr,
        input  rd_data, rd_pend
    );
    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, rd_en, rd_addr, alloc_en, alloc_addr,
        output rd_data, rd_pend
    );
`else
    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, rd_en, rd_addr,
        input  rd_data
    );
    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, rd_en, rd_addr,
        output rd_data
    );
`endif
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read / 2-write GPR file with same-cycle bypass and post-reset clear sweep.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, restarts the clear sweep
//   clr_busy : high from the first reset edge until every entry has been swept
//   bus      : regfile_mp_if.slave, write ports W0/W1 and the packed read ports
//   SCOREBOARD_EN (macro) : adds per-register pending bits, alloc port and rd_pend outputs
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         clr_busy,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    // Entry 0 is hardwired to zero, so no storage is kept for it.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= ADDR_W'(1);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == CLEAR) begin
            if (cnt == '1)
                state_nx = READY;
            else
                cnt_nx = cnt + 1'b1;
        end
    end

    assign clr_busy = (state == CLEAR);

    wire w0_ok = bus.we0 && bus.wa0 != '0;
    wire w1_ok = bus.we1 && bus.wa1 != '0;

    // W1 is assigned last, so on an address collision its value is the one that lands.
    always_ff @(posedge clk) begin
        if (rst_n && state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (rst_n && state == READY) begin
            if (w0_ok) regs[bus.wa0] <= bus.wd0;
            if (w1_ok) regs[bus.wa1] <= bus.wd1;
        end
    end

`ifdef SCOREBOARD_EN
    logic [DEPTH-1:1] pending;

    // Alloc is applied after the write clears: a newer producer keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (state == READY) begin
            if (w0_ok) pending[bus.wa0] <= 1'b0;
            if (w1_ok) pending[bus.wa1] <= 1'b0;
            if (bus.alloc_en && bus.alloc_addr != '0) pending[bus.alloc_addr] <= 1'b1;
        end
    end
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              off, hit1, hit0;
        assign ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign off  = clr_busy || !bus.rd_en[k] || ra == '0;
        assign hit1 = bus.we1 && bus.wa1 == ra;
        assign hit0 = bus.we0 && bus.wa0 == ra;
        assign bus.rd_data[k*DATA_W +: DATA_W] = off  ? '0 :
                                                 hit1 ? bus.wd1 :
                                                 hit0 ? bus.wd0 :
                                                 regs[ra];
`ifdef SCOREBOARD_EN
        // A same-cycle bypass hit means the producer is delivering now, so nothing is pending.
        assign bus.rd_pend[k] = !off && !hit1 && !hit0 && pending[ra];
`endif
    end
endmodule
